// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 data path among four requesters.
// Ownership of the path is bounded by MAX_HOLD consecutive cycles. On release,
// the arbiter hands the path to the next requester in the same edge.
//
// Handshake: req[i] is a level request. The requester keeps it high for as long
// as it wants the path. gnt[i] (registered) marks the current owner. While the
// owner holds req[i] high and has not used up MAX_HOLD cycles, gnt stays on it.
// Dropping req[i] ends the ownership at the next edge. out/out_valid present the
// owner's live data word to the shared consumer in the same cycle.
module rr_mux_arbiter #(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [4*DATA_W-1:0]   data,
  output logic [3:0]            gnt,
  output logic [1:0]            sel,
  output logic [DATA_W-1:0]     out,
  output logic                  out_valid,
  output logic                  state_dbg,
  output logic [3:0]            hold_cnt_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] gnt_q, gnt_d;

  logic       do_grant;
  logic [1:0] win;
  logic       rel;

  // First set bit of r scanning upward from start, wrapping mod 4.
  // The loop runs high-to-low so the closest index is written last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] res;
    res = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) res = idx;
    end
    return res;
  endfunction

  // State register: all arbiter flops, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      hold_q  <= 4'd0;
      gnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
    end
  end

  // Next-state: search for a winner on entry or on release, else extend ownership.
  // An owner still requesting at MAX_HOLD is not masked; starting the search at
  // owner+1 puts it last, so it is re-granted only when nobody else asks.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    gnt_d    = gnt_q;
    do_grant = 1'b0;
    win      = 2'd0;
    rel      = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = 4'd0;
        if (|req) begin
          do_grant = 1'b1;
          win      = rr_pick(req, ptr_q);
        end
      end
      OWN: begin
        rel = !req[sel_q] || (hold_q == MAX_HOLD_C);
        if (!rel) begin
          hold_d = hold_q + 4'd1;
        end else if (|req) begin
          // A dropped owner already reads 0 in req, so req is the remaining set.
          do_grant = 1'b1;
          win      = rr_pick(req, sel_q + 2'd1);
        end else begin
          state_d = IDLE;
          gnt_d   = 4'd0;
          hold_d  = 4'd0;
          ptr_d   = sel_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'd0;
        hold_d  = 4'd0;
      end
    endcase
    if (do_grant) begin
      state_d = OWN;
      sel_d   = win;
      gnt_d   = 4'b0001 << win;
      hold_d  = 4'd1;
      ptr_d   = win + 2'd1;
    end
  end

  // Outputs: registered grant/select, live data steered by the registered select.
  always_comb begin
    gnt          = gnt_q;
    sel          = sel_q;
    out_valid    = (state_q == OWN);
    out          = '0;
    if (state_q == OWN) out = data[sel_q*DATA_W +: DATA_W];
    state_dbg    = state_q;
    hold_cnt_dbg = hold_q;
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: a vector table on a MAX_HOLD=4 instance
// and a full-contention sequence on a MAX_HOLD=2 instance.
module tb_rr_mux_arbiter;

  logic       clk = 1'b0;
  int         n_checks = 0;
  int         n_fail   = 0;

  // MAX_HOLD = 4 instance
  logic       rst4;
  logic [3:0] req4, data4, gnt4;
  logic [1:0] sel4;
  logic [0:0] out4;
  logic       ov4, st4;
  logic [3:0] hold4;

  // MAX_HOLD = 2 instance
  logic       rst2;
  logic [3:0] req2, data2, gnt2;
  logic [1:0] sel2;
  logic [0:0] out2;
  logic       ov2, st2;
  logic [3:0] hold2;

  rr_mux_arbiter #(.DATA_W(1), .MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst4), .req(req4), .data(data4),
    .gnt(gnt4), .sel(sel4), .out(out4), .out_valid(ov4),
    .state_dbg(st4), .hold_cnt_dbg(hold4)
  );

  rr_mux_arbiter #(.DATA_W(1), .MAX_HOLD(2)) dut2 (
    .clk(clk), .rst(rst2), .req(req2), .data(data2),
    .gnt(gnt2), .sel(sel2), .out(out2), .out_valid(ov2),
    .state_dbg(st2), .hold_cnt_dbg(hold2)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] data;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       ov;
    logic       out;
    logic       hchk;
    logic [3:0] hold;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply4(input vec_t v);
    @(negedge clk);
    rst4  = v.rst;
    req4  = v.req;
    data4 = v.data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int own_exp [9];
    rst4 = 1'b1; req4 = 4'h0; data4 = 4'h0;
    rst2 = 1'b1; req2 = 4'h0; data2 = 4'h0;

    // rst, req, data, gnt, sel, ov, out, hchk, hold
    // Reset with all requesting
    vecs[0]  = '{1'b1, 4'hF, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1, 4'd0};
    vecs[1]  = '{1'b1, 4'hF, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1, 4'd0};
    vecs[2]  = '{1'b0, 4'hF, 4'hF, 4'h1, 2'd0, 1'b1, 1'b1, 1'b1, 4'd1};
    vecs[3]  = '{1'b0, 4'h0, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0};
    // Single requester 2 for 10 cycles, hold 1,2,3,4,1,...
    vecs[4]  = '{1'b0, 4'h4, 4'h4, 4'h4, 2'd2, 1'b1, 1'b1, 1'b1, 4'd1};
    vecs[5]  = '{1'b0, 4'h4, 4'h4, 4'h4, 2'd2, 1'b1, 1'b1, 1'b1, 4'd2};
    vecs[6]  = '{1'b0, 4'h4, 4'h4, 4'h4, 2'd2, 1'b1, 1'b1, 1'b1, 4'd3};
    vecs[7]  = '{1'b0, 4'h4, 4'h4, 4'h4, 2'd2, 1'b1, 1'b1, 1'b1, 4'd4};
    vecs[8]  = '{1'b0, 4'h4, 4'h4, 4'h4, 2'd2, 1'b1, 1'b1, 1'b1, 4'd1};
    vecs[9]  = '{1'b0, 4'h4, 4'h4, 4'h4, 2'd2, 1'b1, 1'b1, 1'b1, 4'd2};
    vecs[10] = '{1'b0, 4'h4, 4'h4, 4'h4, 2'd2, 1'b1, 1'b1, 1'b1, 4'd3};
    vecs[11] = '{1'b0, 4'h4, 4'h4, 4'h4, 2'd2, 1'b1, 1'b1, 1'b1, 4'd4};
    vecs[12] = '{1'b0, 4'h4, 4'h4, 4'h4, 2'd2, 1'b1, 1'b1, 1'b1, 4'd1};
    vecs[13] = '{1'b0, 4'h4, 4'h4, 4'h4, 2'd2, 1'b1, 1'b1, 1'b1, 4'd2};
    // Idle: sel keeps 2
    vecs[14] = '{1'b0, 4'h0, 4'hF, 4'h0, 2'd2, 1'b0, 1'b0, 1'b0, 4'd0};
    // Early release: owner 1, then 3 joins, 1 drops, 2 skipped
    vecs[15] = '{1'b0, 4'h2, 4'h2, 4'h2, 2'd1, 1'b1, 1'b1, 1'b1, 4'd1};
    vecs[16] = '{1'b0, 4'hA, 4'h8, 4'h2, 2'd1, 1'b1, 1'b0, 1'b1, 4'd2};
    vecs[17] = '{1'b0, 4'h8, 4'h8, 4'h8, 2'd3, 1'b1, 1'b1, 1'b1, 4'd1};
    // Drain to idle, sel stays 3, then ptr=0 grants 0 first
    vecs[18] = '{1'b0, 4'h0, 4'hF, 4'h0, 2'd3, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[19] = '{1'b0, 4'h9, 4'h1, 4'h1, 2'd0, 1'b1, 1'b1, 1'b1, 4'd1};
    // Owner 2 to hold 3, then reset, then restart from ptr=0
    vecs[20] = '{1'b0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[21] = '{1'b0, 4'h4, 4'h4, 4'h4, 2'd2, 1'b1, 1'b1, 1'b1, 4'd1};
    vecs[22] = '{1'b0, 4'h4, 4'h4, 4'h4, 2'd2, 1'b1, 1'b1, 1'b1, 4'd2};
    vecs[23] = '{1'b0, 4'h4, 4'h4, 4'h4, 2'd2, 1'b1, 1'b1, 1'b1, 4'd3};
    vecs[24] = '{1'b1, 4'h4, 4'h4, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1, 4'd0};
    vecs[25] = '{1'b0, 4'hF, 4'hF, 4'h1, 2'd0, 1'b1, 1'b1, 1'b1, 4'd1};

    for (int i = 0; i < NV; i++) begin
      apply4(vecs[i]);
      check($sformatf("v%0d gnt", i), 32'(gnt4), 32'(vecs[i].gnt));
      check($sformatf("v%0d sel", i), 32'(sel4), 32'(vecs[i].sel));
      check($sformatf("v%0d out_valid", i), 32'(ov4), 32'(vecs[i].ov));
      check($sformatf("v%0d out", i), 32'(out4), 32'(vecs[i].out));
      if (vecs[i].hchk) check($sformatf("v%0d hold_cnt", i), 32'(hold4), 32'(vecs[i].hold));
    end

    // Full contention with MAX_HOLD=2: owners 0,0,1,1,2,2,3,3,0 with no gaps
    own_exp = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    @(negedge clk);
    rst2 = 1'b1; req2 = 4'hF; data2 = 4'b1010;
    @(posedge clk); #1;
    check("mh2 reset gnt", 32'(gnt2), 32'h0);
    @(negedge clk);
    rst2 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << own_exp[i];
      @(posedge clk); #1;
      check($sformatf("mh2 c%0d gnt", i), 32'(gnt2), 32'(exp_g));
      check($sformatf("mh2 c%0d sel", i), 32'(sel2), 32'(own_exp[i]));
      check($sformatf("mh2 c%0d out_valid", i), 32'(ov2), 32'h1);
      check($sformatf("mh2 c%0d out", i), 32'(out2), 32'(data2[own_exp[i]]));
      check($sformatf("mh2 c%0d hold_cnt", i), 32'(hold2), 32'((i % 2) + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
